// File: rtl/mmio_pkg.sv
// Shared constants, state encodings and the write-request record for the MMIO console slave.
package mmio_pkg;

    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] DEF_PASS_ADDR    = 32'h2000_0000;
    localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;
    localparam logic [31:0] RDATA_UNMAPPED   = 32'hDEAD_BEEF;
    localparam logic [31:0] STATUS_OFFSET    = 32'd4;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_COLLECT = 2'd1,
        W_EXEC    = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Latched AW/W contents of the single outstanding write
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

    // Status register layout: bit 8 = full, bits 7:0 = entry count
    function automatic logic [31:0] status_word(input logic full, input logic [7:0] level);
        return {23'b0, full, level};
    endfunction

endpackage

// File: rtl/mmio_byte_fifo.sv
// Byte FIFO feeding the console stream. Head byte comes straight from flops so it
// holds steady while the consumer stalls; full is the registered count, so a pop
// while full does not free a slot for a push in the same cycle.
module mmio_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic [7:0] o_level,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_valid   = !o_empty;
    assign o_data    = o_valid ? r_mem[r_rptr] : 8'h00;
    assign o_level   = 8'(r_level);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage array; contents are don't-care until the level says otherwise
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_data;
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracked separately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/axi_mmio_console.sv
// AXI4-lite MMIO slave: console byte TX FIFO, sticky test-pass flag and an
// unmapped-access flag. Independent single-outstanding write and read engines.
module axi_mmio_console
    import mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
    parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        tests_passed,
    output logic        bad_access
);

    localparam logic [31:0] STATUS_ADDR = CONSOLE_ADDR + STATUS_OFFSET;

    w_state_t    r_wstate, w_wstate_nxt;
    r_state_t    r_rstate, w_rstate_nxt;
    wr_req_t     r_req;
    logic        r_aw_got, r_w_got;
    logic        r_awready, r_wready, r_arready;
    logic [31:0] r_rdata;
    logic        r_tests_passed, r_bad_access;

    logic        w_aw_hs, w_w_hs, w_ar_hs;
    logic        w_exec, w_is_console, w_is_pass, w_console_push, w_pass_hit, w_exec_done;
    logic        w_fifo_push, w_fifo_pop, w_fifo_full, w_fifo_empty, w_fifo_valid;
    logic [7:0]  w_fifo_data, w_fifo_level;
    logic [31:0] w_rd_data;
    logic        w_rd_bad;
    logic        w_unused;

    assign w_aw_hs        = mem_axi_awvalid && r_awready;
    assign w_w_hs         = mem_axi_wvalid && r_wready;
    assign w_ar_hs        = mem_axi_arvalid && r_arready;

    assign w_exec         = (r_wstate == W_EXEC);
    assign w_is_console   = (r_req.addr == CONSOLE_ADDR);
    assign w_is_pass      = (r_req.addr == PASS_ADDR);
    assign w_console_push = w_is_console && r_req.strb[0];
    assign w_pass_hit     = w_is_pass && (r_req.data == PASS_MAGIC) && (r_req.strb == 4'hF);
    // A console byte with a full FIFO holds the write in EXEC until a slot opens
    assign w_exec_done    = w_exec && !(w_console_push && w_fifo_full);
    assign w_fifo_push    = w_exec && w_console_push && !w_fifo_full;
    assign w_fifo_pop     = w_fifo_valid && tx_ready;

    assign mem_axi_awready = r_awready;
    assign mem_axi_wready  = r_wready;
    assign mem_axi_bvalid  = (r_wstate == W_RESP);
    assign mem_axi_arready = r_arready;
    assign mem_axi_rvalid  = (r_rstate == R_DATA);
    assign mem_axi_rdata   = r_rdata;
    assign tx_valid        = w_fifo_valid;
    assign tx_data         = w_fifo_data;
    assign tests_passed    = r_tests_passed;
    assign bad_access      = r_bad_access;
    assign w_unused        = ^{mem_axi_awprot, mem_axi_arprot, w_fifo_empty};

    mmio_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_fifo_push),
        .i_data  (r_req.data[7:0]),
        .i_pop   (w_fifo_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_level (w_fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Write FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_wstate <= W_IDLE;
        else         r_wstate <= w_wstate_nxt;
    end

    // Write FSM next state: collect AW and W in any order, execute, then respond
    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE:    if (mem_axi_awvalid || mem_axi_wvalid) w_wstate_nxt = W_COLLECT;
            W_COLLECT: if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) w_wstate_nxt = W_EXEC;
            W_EXEC:    if (w_exec_done) w_wstate_nxt = W_RESP;
            W_RESP:    if (mem_axi_bready) w_wstate_nxt = W_IDLE;
        endcase
    end

    // AW/W ready pulses and request latching; latches clear once the response is taken
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_req     <= '0;
        end else begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            if (r_wstate == W_IDLE || r_wstate == W_COLLECT) begin
                if (mem_axi_awvalid && !r_aw_got && !r_awready) r_awready <= 1'b1;
                if (mem_axi_wvalid && !r_w_got && !r_wready)    r_wready  <= 1'b1;
            end
            if (w_aw_hs) begin
                r_aw_got   <= 1'b1;
                r_req.addr <= mem_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_got    <= 1'b1;
                r_req.data <= mem_axi_wdata;
                r_req.strb <= mem_axi_wstrb;
            end
            if (r_wstate == W_RESP && mem_axi_bready) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
            end
        end
    end

    // Read data decode from the live address; status reflects the pre-push level
    always_comb begin
        w_rd_data = RDATA_UNMAPPED;
        w_rd_bad  = 1'b0;
        if (mem_axi_araddr == STATUS_ADDR)       w_rd_data = status_word(w_fifo_full, w_fifo_level);
        else if (mem_axi_araddr == PASS_ADDR)    w_rd_data = {31'b0, r_tests_passed};
        else if (mem_axi_araddr == CONSOLE_ADDR) w_rd_data = 32'h0;
        else                                     w_rd_bad  = 1'b1;
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_rstate <= R_IDLE;
        else         r_rstate <= w_rstate_nxt;
    end

    // Read FSM next state: accept address, then hold data until taken
    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA: if (mem_axi_rready) w_rstate_nxt = R_IDLE;
        endcase
    end

    // AR ready pulse and registered read data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_arready <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= (r_rstate == R_IDLE) && mem_axi_arvalid && !r_arready;
            if (w_ar_hs) r_rdata <= w_rd_data;
        end
    end

    // Sticky pass and bad-access flags; only reset clears them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tests_passed <= 1'b0;
            r_bad_access   <= 1'b0;
        end else begin
            if (w_exec && w_pass_hit) r_tests_passed <= 1'b1;
            if ((w_exec && !w_is_console && !w_is_pass) || (w_ar_hs && w_rd_bad))
                r_bad_access <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_mmio_console.sv
// Directed bench for axi_mmio_console with a transaction-level reference model
// and a per-cycle output compare.
module tb_axi_mmio_console;

    localparam int          DEPTH = 16;
    localparam logic [31:0] CON   = 32'h1000_0000;
    localparam logic [31:0] STAT  = 32'h1000_0004;
    localparam logic [31:0] PASS  = 32'h2000_0000;
    localparam logic [31:0] MAGIC = 32'd123456789;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_axi_awvalid = 1'b0, mem_axi_awready;
    logic [31:0] mem_axi_awaddr = '0;
    logic [2:0]  mem_axi_awprot = '0;
    logic        mem_axi_wvalid = 1'b0, mem_axi_wready;
    logic [31:0] mem_axi_wdata = '0;
    logic [3:0]  mem_axi_wstrb = '0;
    logic        mem_axi_bvalid, mem_axi_bready = 1'b1;
    logic        mem_axi_arvalid = 1'b0, mem_axi_arready;
    logic [31:0] mem_axi_araddr = '0;
    logic [2:0]  mem_axi_arprot = '0;
    logic        mem_axi_rvalid, mem_axi_rready = 1'b1;
    logic [31:0] mem_axi_rdata;
    logic        tx_valid, tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tests_passed, bad_access;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0]  q[$];
    logic [7:0]  tx_log[$];
    bit          m_tp = 0, m_bad = 0, m_b = 0, m_r = 0, m_aw = 0, m_w = 0, m_exec = 0;
    logic [31:0] m_rdata = '0, m_addr = '0, m_data = '0;
    logic [3:0]  m_strb = '0;

    axi_mmio_console dut (
        .clk(clk), .resetn(resetn),
        .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
        .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
        .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
        .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
        .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
        .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
        .mem_axi_rdata(mem_axi_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tests_passed(tests_passed), .bad_access(bad_access)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: transaction semantics evaluated at each clock edge
    initial begin : model
        int lvl;
        bit pop, done;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                q.delete();
                m_tp = 0; m_bad = 0; m_b = 0; m_r = 0;
                m_aw = 0; m_w = 0; m_exec = 0; m_rdata = '0;
            end else begin
                lvl = q.size();
                pop = (lvl != 0) && tx_ready;
                if (m_r && mem_axi_rready) m_r = 0;
                if (mem_axi_arvalid && mem_axi_arready) begin
                    m_r = 1;
                    if (mem_axi_araddr == STAT)      m_rdata = {23'b0, lvl == DEPTH, 8'(lvl)};
                    else if (mem_axi_araddr == PASS) m_rdata = {31'b0, m_tp};
                    else if (mem_axi_araddr == CON)  m_rdata = 32'h0;
                    else begin m_rdata = 32'hDEAD_BEEF; m_bad = 1; end
                end
                if (m_b && mem_axi_bready) m_b = 0;
                if (m_exec) begin
                    done = 1;
                    if (m_addr == CON) begin
                        if (m_strb[0]) begin
                            if (lvl < DEPTH) q.push_back(m_data[7:0]);
                            else done = 0;
                        end
                    end else if (m_addr == PASS) begin
                        if (m_data == MAGIC && m_strb == 4'hF) m_tp = 1;
                    end else begin
                        m_bad = 1;
                    end
                    if (done) begin m_exec = 0; m_b = 1; end
                end
                if (mem_axi_awvalid && mem_axi_awready) begin m_aw = 1; m_addr = mem_axi_awaddr; end
                if (mem_axi_wvalid && mem_axi_wready) begin
                    m_w = 1; m_data = mem_axi_wdata; m_strb = mem_axi_wstrb;
                end
                if (m_aw && m_w) begin m_exec = 1; m_aw = 0; m_w = 0; end
                if (pop) void'(q.pop_front());
            end
        end
    end

    // Record bytes actually taken from the DUT stream
    initial forever begin
        @(posedge clk);
        if (resetn && tx_valid && tx_ready) tx_log.push_back(tx_data);
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (resetn) begin
            chk("tx_valid", tx_valid, q.size() != 0);
            if (q.size() != 0) chk("tx_data", tx_data, q[0]);
            chk("bvalid", mem_axi_bvalid, m_b);
            chk("rvalid", mem_axi_rvalid, m_r);
            if (m_r) chk("rdata", mem_axi_rdata, m_rdata);
            chk("tests_passed", tests_passed, m_tp);
            chk("bad_access", bad_access, m_bad);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Issue AW and W; AW is delayed by 'lead' cycles after W. Returns when both accepted.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lead, output bit acc);
        bit aw_done, w_done;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        mem_axi_awaddr = a; mem_axi_wdata = d; mem_axi_wstrb = s;
        mem_axi_wvalid = 1'b1;
        mem_axi_awvalid = (lead == 0);
        while (!(aw_done && w_done) && n < 40) begin
            @(posedge clk);
            if (mem_axi_awvalid && mem_axi_awready) aw_done = 1;
            if (mem_axi_wvalid && mem_axi_wready) w_done = 1;
            #1;
            n++;
            if (aw_done) mem_axi_awvalid = 1'b0;
            if (w_done)  mem_axi_wvalid = 1'b0;
            if (!aw_done && n == lead) mem_axi_awvalid = 1'b1;
        end
        mem_axi_awvalid = 1'b0;
        mem_axi_wvalid = 1'b0;
        acc = aw_done && w_done;
    endtask

    task automatic wait_b(input int lim, output int cyc, output bit ok);
        ok = 0; cyc = 0;
        while (!ok && cyc < lim) begin
            @(posedge clk);
            cyc++;
            if (mem_axi_bvalid && mem_axi_bready) ok = 1;
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output bit ok);
        bit hs;
        int n;
        hs = 0; ok = 0; n = 0; d = 'x;
        mem_axi_araddr = a; mem_axi_arvalid = 1'b1;
        while (!hs && n < 20) begin
            @(posedge clk);
            if (mem_axi_arvalid && mem_axi_arready) hs = 1;
            #1; n++;
        end
        mem_axi_arvalid = 1'b0;
        n = 0;
        while (hs && !ok && n < 20) begin
            @(posedge clk);
            if (mem_axi_rvalid && mem_axi_rready) begin ok = 1; d = mem_axi_rdata; end
            #1; n++;
        end
    endtask

    // 16 console writes that each complete, then a 17th that is accepted but stalls
    task automatic fill17(input logic [7:0] base, output int nb);
        bit acc, ok;
        int c;
        nb = 0;
        for (int i = 0; i < 17; i++) begin
            wr(CON, {24'hABCDEF, 8'(base + 8'(i))}, 4'hF, 0, acc);
            chk("fill_accept", acc, 1);
            if (i < 16) begin
                wait_b(20, c, ok);
                if (ok) nb++;
            end
        end
    endtask

    task automatic wait_log(input int n, output bit ok);
        int c;
        c = 0;
        while (tx_log.size() < n && c < 200) begin @(posedge clk); #1; c++; end
        ok = (tx_log.size() == n);
    endtask

    initial begin
        bit acc, ok;
        int cyc, nb;
        logic [31:0] d;

        // reset state
        #1;
        chk("rst_ctl", {mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready,
                        mem_axi_rvalid, tx_valid, tests_passed, bad_access}, 0);
        chk("rst_rdata", mem_axi_rdata, 0);
        chk("rst_txdata", tx_data, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // 1: single console byte, 2-cycle write response latency
        tx_ready = 1'b1;
        wr(CON, 32'h0000_0041, 4'hF, 0, acc);
        chk("t1_accept", acc, 1);
        wait_b(20, cyc, ok);
        chk("t1_bresp", ok, 1);
        chk("t1_latency", cyc, 2);
        wait_log(1, ok);
        chk("t1_log_n", ok, 1);
        if (ok) chk("t1_byte", tx_log[0], 8'h41);

        // 2: fill past capacity with consumer stalled
        tx_ready = 1'b0;
        fill17(8'h50, nb);
        chk("t2_bresp_count", nb, 16);
        repeat (6) @(negedge clk);
        chk("t2_stalled_bvalid", mem_axi_bvalid, 0);
        @(posedge clk); #1;
        rd(STAT, d, ok);
        chk("t2_rd_ok", ok, 1);
        chk("t2_status", d, 32'h0000_0110);
        tx_ready = 1'b1;
        wait_b(40, cyc, ok);
        chk("t2_17th_bresp", ok, 1);
        wait_log(18, ok);
        chk("t2_log_n", ok, 1);
        if (ok) for (int i = 0; i < 17; i++) chk("t2_order", tx_log[1+i], 32'h50 + 32'(i));

        // 3: pass flag
        wr(PASS, MAGIC - 1, 4'hF, 0, acc); wait_b(20, cyc, ok);
        chk("t3_near_magic", tests_passed, 0);
        wr(PASS, MAGIC, 4'h7, 0, acc); wait_b(20, cyc, ok);
        chk("t3_partial_strb", tests_passed, 0);
        wr(PASS, MAGIC, 4'hF, 0, acc); wait_b(20, cyc, ok);
        chk("t3_magic", tests_passed, 1);
        wr(PASS, 32'h0, 4'hF, 0, acc); wait_b(20, cyc, ok);
        chk("t3_sticky", tests_passed, 1);
        rd(PASS, d, ok);
        chk("t3_rd_pass", d, 32'h1);

        // 4: W leads AW by 3 cycles, response held off by bready
        mem_axi_bready = 1'b0;
        wr(CON, 32'h0000_00C3, 4'h1, 3, acc);
        chk("t4_accept", acc, 1);
        @(posedge clk);
        repeat (5) begin @(negedge clk); chk("t4_bvalid_hold", mem_axi_bvalid, 1); end
        @(posedge clk); #1;
        mem_axi_bready = 1'b1;
        wait_b(5, cyc, ok);
        chk("t4_bresp", ok, 1);
        repeat (2) @(posedge clk); #1;
        chk("t4_bvalid_once", mem_axi_bvalid, 0);
        wait_log(19, ok);
        chk("t4_log_n", ok, 1);
        if (ok) chk("t4_byte", tx_log[18], 8'hC3);

        // 5: unmapped read, write to read-only status, console write without byte lane 0
        chk("t5_bad_before", bad_access, 0);
        rd(32'h3000_0000, d, ok);
        chk("t5_deadbeef", d, 32'hDEAD_BEEF);
        chk("t5_bad_after", bad_access, 1);
        wr(STAT, 32'h0000_0077, 4'hF, 0, acc); wait_b(20, cyc, ok);
        chk("t5_stat_bresp", ok, 1);
        wr(CON, 32'h0000_0077, 4'hE, 0, acc); wait_b(20, cyc, ok);
        chk("t5_nostrb_bresp", ok, 1);
        repeat (4) @(posedge clk); #1;
        chk("t5_no_push", tx_log.size(), 19);
        rd(STAT, d, ok);
        chk("t5_status_empty", d, 32'h0);
        rd(CON, d, ok);
        chk("t5_rd_console", d, 32'h0);

        // 6: async reset during a backpressured write
        tx_ready = 1'b0;
        fill17(8'h60, nb);
        chk("t6_bresp_count", nb, 16);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("t6_rst_ctl", {mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready,
                           mem_axi_rvalid, tx_valid, tests_passed, bad_access}, 0);
        chk("t6_rst_rdata", mem_axi_rdata, 0);
        chk("t6_rst_txdata", tx_data, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        tx_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t6_no_bvalid", mem_axi_bvalid, 0);
            chk("t6_fifo_empty", tx_valid, 0);
        end
        @(posedge clk); #1;
        rd(STAT, d, ok);
        chk("t6_status", d, 32'h0);
        wr(CON, 32'h0000_005A, 4'hF, 0, acc); wait_b(20, cyc, ok);
        chk("t6_post_bresp", ok, 1);
        wait_log(20, ok);
        chk("t6_log_n", ok, 1);
        if (ok) chk("t6_byte", tx_log[19], 8'h5A);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
